// File: rtl/csa_mul_seq.sv
// Sequential radix-2 shift-add multiplier that keeps the running product in
// carry-save form and resolves it with a single carry-propagate add.

module csa #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] ps,
   output logic [WIDTH-1:0] pc
);

   assign ps = a ^ b ^ d;
   assign pc = (a & b) | (a & d) | (b & d);

endmodule

module csa_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] ps;
   logic [WIDTH-1:0] pc;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] pp;
   logic [WIDTH-1:0] pc_sh;
   logic [WIDTH-1:0] csa_ps;
   logic [WIDTH-1:0] csa_pc;
   logic             accept;
   logic             last_accum;

   // Carry-propagate add that collapses the redundant accumulator; the carry
   // out of the top bit is discarded, leaving the product modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] cpa(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
      return x + y;
   endfunction

   assign in_ready   = (state == IDLE) && !rst;
   assign busy       = ((state == ACCUM) || (state == RESOLVE)) && !rst;
   assign accept     = in_valid && in_ready;

   // Leave the loop once no set multiplier bits remain above the current one.
   assign last_accum = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);

   assign pp    = mplier[0] ? mcand : '0;
   assign pc_sh = pc << 1;

   csa #(.WIDTH(WIDTH)) u_csa (
      .a  (ps),
      .b  (pc_sh),
      .d  (pp),
      .ps (csa_ps),
      .pc (csa_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (b == '0) ? RESOLVE : ACCUM;
            end
         end
         ACCUM: begin
            if (last_accum) begin
               state_nxt = RESOLVE;
            end
         end
         RESOLVE: begin
            state_nxt = OUT;
         end
         OUT: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand     <= '0;
         mplier    <= '0;
         ps        <= '0;
         pc        <= '0;
         cnt       <= '0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= a;
                  mplier <= b;
                  ps     <= '0;
                  pc     <= '0;
                  cnt    <= '0;
               end
            end
            ACCUM: begin
               ps     <= csa_ps;
               pc     <= csa_pc;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
            end
            RESOLVE: begin
               result    <= cpa(ps, pc_sh);
               out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_mul_seq.sv
// Directed and randomised checks of csa_mul_seq: results, latency, busy,
// backpressure, mid-operation reset and in-order streaming.

module tb_csa_mul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   csa_mul_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   // Issue one operation, count cycles from the accept edge to out_valid and
   // the busy cycles in between, then complete the result handshake.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat, output int bsy);
      a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
      lat = 0; bsy = 0;
      for (int i = 0; i < 100 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
         if (busy) bsy++;
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 32'd3; b = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got ov=%b busy=%b ir=%b want 0 0 0", out_valid, busy, in_ready);
      end
      vectors++;
      if (result !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_result got %h want 00000000", result);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release got ir=%b busy=%b want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_basic;
      logic [31:0] av [2] = '{32'd7, 32'h12345678};
      logic [31:0] bv [2] = '{32'd6, 32'd1};
      logic [31:0] ev [2] = '{32'd42, 32'h12345678};
      int          el [2] = '{4, 2};
      logic [31:0] r;
      int          l, bz;
      for (int i = 0; i < 2; i++) begin
         do_op(av[i], bv[i], r, l, bz);
         vectors++;
         if (r !== ev[i]) begin
            miscompares++;
            $display("FAIL basic_result[%0d] got %h want %h", i, r, ev[i]);
         end
         vectors++;
         if (l !== el[i] || bz !== el[i]) begin
            miscompares++;
            $display("FAIL basic_timing[%0d] got lat=%0d busy=%0d want %0d", i, l, bz, el[i]);
         end
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after_hs[%0d] got ov=%b ir=%b want 0 1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_zero;
      logic [31:0] r;
      int          l, bz;
      do_op(32'hDEADBEEF, 32'd0, r, l, bz);
      vectors++;
      if (r !== 32'd0) begin
         miscompares++;
         $display("FAIL zero_result got %h want 00000000", r);
      end
      vectors++;
      if (l !== 1 || bz !== 1) begin
         miscompares++;
         $display("FAIL zero_timing got lat=%0d busy=%0d want 1 1", l, bz);
      end
   endtask

   task automatic test_full_width;
      logic [31:0] av [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd3};
      logic [31:0] bv [3] = '{32'hFFFFFFFF, 32'd5, 32'h80000000};
      logic [31:0] ev [3] = '{32'h00000001, 32'hFFFFFFF1, 32'h80000000};
      int          el [3] = '{33, 4, 33};
      logic [31:0] r;
      int          l, bz;
      for (int i = 0; i < 3; i++) begin
         do_op(av[i], bv[i], r, l, bz);
         vectors++;
         if (r !== ev[i]) begin
            miscompares++;
            $display("FAIL full_result[%0d] got %h want %h", i, r, ev[i]);
         end
         vectors++;
         if (l !== el[i] || bz !== el[i]) begin
            miscompares++;
            $display("FAIL full_timing[%0d] got lat=%0d busy=%0d want %0d", i, l, bz, el[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      int n;
      int bad;
      a = 32'd9; b = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'd100; b = 32'd3;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || result !== 32'd81 || in_ready !== 1'b0 || busy !== 1'b0)
            bad++;
         @(posedge clk); #1;
      end
      vectors++;
      if (bad !== 0 || n !== 5) begin
         miscompares++;
         $display("FAIL bp_hold got %0d unstable cycles lat=%0d want 0 lat=5", bad, n);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_handshake got ov=%b ir=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (result !== 32'd300 || n !== 3) begin
         miscompares++;
         $display("FAIL bp_second got result=%0d lat=%0d want 300 lat=3", result, n);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [31:0] r;
      int          l, bz, seen;
      a = 32'd3; b = 32'h80000000; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_busy got %b want 1", busy);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_during got busy=%b ir=%b want 0 0", busy, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_after got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL rstmid_no_output got %0d valid cycles want 0", seen);
      end
      out_ready = 1'b0;
      do_op(32'd5, 32'd5, r, l, bz);
      vectors++;
      if (r !== 32'd25 || l !== 4) begin
         miscompares++;
         $display("FAIL rstmid_followup got result=%0d lat=%0d want 25 lat=4", r, l);
      end
   endtask

   task automatic test_streaming;
      logic [31:0] q[$];
      logic [31:0] exp_r;
      logic [31:0] na, nb;
      int          issued, got, cyc;
      bit          have;
      issued = 0; got = 0; cyc = 0; have = 1'b0;
      na = 32'd0; nb = 32'd0;
      while (got < 200 && cyc < 60000) begin
         if (!have && issued < 200) begin
            na = $urandom;
            nb = $urandom >> $urandom_range(0, 31);
            have = 1'b1;
         end
         a = na; b = nb;
         in_valid  = have && ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 2) != 0);
         if (in_valid && in_ready) begin
            q.push_back(na * nb);
            issued++;
            have = 1'b0;
         end
         if (out_valid && out_ready) begin
            got++;
            exp_r = (q.size() > 0) ? q.pop_front() : ~result;
            vectors++;
            if (result !== exp_r) begin
               miscompares++;
               $display("FAIL stream[%0d] got %h want %h", got, result, exp_r);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (got !== 200 || issued !== 200 || q.size() !== 0) begin
         miscompares++;
         $display("FAIL stream_count got issued=%0d results=%0d pending=%0d want 200 200 0",
                  issued, got, q.size());
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      test_reset;
      test_basic;
      test_zero;
      test_full_width;
      test_backpressure;
      test_reset_mid;
      test_streaming;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
